// File: rtl/alu_ctrl_muldiv_if.sv
// Issue/result bus between main control, the ALU control block and the datapath.
// The master side drives the instruction fields and the slave side returns the controls.
interface alu_ctrl_muldiv_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
);
  logic [1:0]        ALUOp;
  logic [5:0]        funct;
  logic              valid;
  logic [WIDTH-1:0]  rs_val;
  logic [WIDTH-1:0]  rt_val;
  logic [CTRL_W-1:0] ALU_control_out;
  logic [WIDTH-1:0]  hilo_out;
  logic              hilo_sel;
  logic              stall;
  logic              busy;
  logic              done;

  modport master (
    output ALUOp, funct, valid, rs_val, rt_val,
    input  ALU_control_out, hilo_out, hilo_sel, stall, busy, done
  );

  modport slave (
    input  ALUOp, funct, valid, rs_val, rt_val,
    output ALU_control_out, hilo_out, hilo_sel, stall, busy, done
  );
endinterface

// File: rtl/alu_ctrl_muldiv.sv
// ALU control decode plus an iterative multiply/divide engine with HI/LO registers.
// Mult/div take WIDTH cycles in RUN; a zero divisor completes on the next edge.
module alu_ctrl_muldiv #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_ctrl_muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] hi, lo, acc, sh, opb;
  logic [CNT_W-1:0] count;
  logic             is_div, neg_q, neg_r;

  logic [2:0] alu_code;
  always_comb begin
    alu_code = 3'b010;
    case (bus.ALUOp)
      2'b01: alu_code = 3'b110;
      2'b11: alu_code = 3'b111;
      2'b10: begin
        case (bus.funct)
          6'b100010: alu_code = 3'b110;
          6'b100100: alu_code = 3'b000;
          6'b100101: alu_code = 3'b001;
          6'b101010: alu_code = 3'b111;
          default:   alu_code = 3'b010;
        endcase
      end
      default: alu_code = 3'b010;
    endcase
  end
  assign bus.ALU_control_out = CTRL_W'(alu_code);

  logic rtype, op_mult, op_multu, op_div, op_divu, op_mfhi, op_mflo, op_mthi, op_mtlo;
  logic md_class, md_iter_op, can_issue, start, div0;
  assign rtype      = (bus.ALUOp == 2'b10);
  assign op_mult    = rtype && (bus.funct == 6'b011000);
  assign op_multu   = rtype && (bus.funct == 6'b011001);
  assign op_div     = rtype && (bus.funct == 6'b011010);
  assign op_divu    = rtype && (bus.funct == 6'b011011);
  assign op_mfhi    = rtype && (bus.funct == 6'b010000);
  assign op_mflo    = rtype && (bus.funct == 6'b010010);
  assign op_mthi    = rtype && (bus.funct == 6'b010001);
  assign op_mtlo    = rtype && (bus.funct == 6'b010011);
  assign md_iter_op = op_mult | op_multu | op_div | op_divu;
  assign md_class   = md_iter_op | op_mfhi | op_mflo | op_mthi | op_mtlo;
  assign can_issue  = (state != RUN);
  assign start      = bus.valid && md_iter_op && can_issue;
  assign div0       = (op_div | op_divu) && (bus.rt_val == '0);

  // Signed ops iterate on magnitudes; signs are reapplied on the final edge.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = (op_mult | op_div) && bus.rs_val[WIDTH-1];
  assign b_neg = (op_mult | op_div) && bus.rt_val[WIDTH-1];
  assign a_mag = a_neg ? -bus.rs_val : bus.rs_val;
  assign b_mag = b_neg ? -bus.rt_val : bus.rt_val;

  logic [WIDTH:0]     m_sum, d_rem;
  logic [WIDTH-1:0]   d_diff, acc_step, sh_step, q_res, r_res, hi_res, lo_res;
  logic               d_ge;
  logic [2*WIDTH-1:0] prod_mag, prod;
  always_comb begin
    m_sum  = {1'b0, acc} + (sh[0] ? {1'b0, opb} : '0);
    d_rem  = {acc, sh[WIDTH-1]};
    d_ge   = (d_rem >= {1'b0, opb});
    d_diff = d_rem[WIDTH-1:0] - opb;
    if (is_div) begin
      acc_step = d_ge ? d_diff : d_rem[WIDTH-1:0];
      sh_step  = {sh[WIDTH-2:0], d_ge};
    end else begin
      acc_step = m_sum[WIDTH:1];
      sh_step  = {m_sum[0], sh[WIDTH-1:1]};
    end
    prod_mag = {acc_step, sh_step};
    prod     = neg_q ? -prod_mag : prod_mag;
    q_res    = neg_q ? -sh_step : sh_step;
    r_res    = neg_r ? -acc_step : acc_step;
    hi_res   = is_div ? r_res : prod[2*WIDTH-1:WIDTH];
    lo_res   = is_div ? q_res : prod[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = start ? (div0 ? DONE : RUN) : IDLE;
      RUN:        if (count == CNT_W'(1)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state == RUN);
    bus.done     = (state == DONE);
    bus.stall    = 1'b0;
    bus.hilo_sel = 1'b0;
    bus.hilo_out = '0;
    if (rst_n && bus.valid && md_class)
      bus.stall = (state == RUN) || (md_iter_op && !div0);
    if (rst_n && bus.valid && can_issue) begin
      if (op_mfhi) begin
        bus.hilo_sel = 1'b1;
        bus.hilo_out = hi;
      end else if (op_mflo) begin
        bus.hilo_sel = 1'b1;
        bus.hilo_out = lo;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      sh     <= '0;
      opb    <= '0;
      count  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (start) begin
      if (div0) begin
        hi <= bus.rs_val;
        lo <= '1;
      end else begin
        acc    <= '0;
        sh     <= a_mag;
        opb    <= b_mag;
        count  <= CNT_W'(WIDTH);
        is_div <= op_div | op_divu;
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
      end
    end else if (state == RUN) begin
      acc   <= acc_step;
      sh    <= sh_step;
      count <= count - CNT_W'(1);
      if (count == CNT_W'(1)) begin
        hi <= hi_res;
        lo <= lo_res;
      end
    end else if (bus.valid && can_issue) begin
      if (op_mthi) hi <= bus.rs_val;
      if (op_mtlo) lo <= bus.rs_val;
    end
  end
endmodule

// File: doc/alu_ctrl_muldiv.md
Name: alu_ctrl_muldiv

Overview:
Parametrised next-generation ALU control for the MIPS core.
- Keeps the combinational ALUOp/funct decode to the ALU control bus.
- Adds an iterative multiply/divide engine with HI/LO registers and a stall interlock (mult, multu, div, divu, mfhi, mflo, mthi, mtlo).
- Sits between the main control/ID logic and the datapath ALU; `stall` freezes PC and the IF/ID state while the engine is busy.

Parameters:
- WIDTH, 32, operand/HI/LO width (even, ≥4).
- CTRL_W, 3, ALU control bus width; codes occupy the low 3 bits, upper bits are zero.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ALUOp  in  2  from main control.
- funct  in  6  instruction[5:0].
- valid  in  1  instruction is being issued this cycle.
- rs_val  in  WIDTH  operand A (multiplicand/dividend, mthi/mtlo source).
- rt_val  in  WIDTH  operand B (multiplier/divisor).
- ALU_control_out  out  CTRL_W  ALU operation code.
- hilo_out  out  WIDTH  HI for mfhi, LO for mflo, else 0.
- hilo_sel  out  1  1 when the writeback mux must take hilo_out.
- stall  out  1  hold issue.
- busy  out  1  engine iterating.
- done  out  1  one-cycle pulse when HI/LO have just been updated by mult/div.

Behaviour:
- Decode (combinational, independent of state):
  - ALUOp 00 → 010 (add).
  - ALUOp 01 → 110 (sub).
  - ALUOp 11 → 111 (slt).
  - ALUOp 10 by funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
  - Any other funct → 010.
- Mul/div ops are recognised only when ALUOp == 10: funct 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010010 mflo, 010001 mthi, 010011 mtlo.
- FSM states IDLE, RUN, DONE.
  - IDLE: valid & mul/div op → latch operands, count = WIDTH, go to RUN. Signed ops latch magnitudes and record result signs.
  - RUN: one shift-add (mult) or restoring shift-subtract (div) step per cycle. count decrements. At count == 1 the edge writes HI/LO (sign-corrected) and goes to DONE.
  - DONE: done = 1 for one cycle, then IDLE. A new mul/div op may issue in DONE and goes straight to RUN.
- Latency: issue in cycle N → busy high in N+1..N+WIDTH → done high in N+WIDTH+1, with HI/LO valid in that cycle.
- Divide by zero: skip iteration, IDLE → DONE directly. HI = rs_val, LO = all ones, done in N+1.
- Division results:
  - div: LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
  - div of most-negative by −1: LO = most-negative, HI = 0.
- Multiply results:
  - mult: signed 2·WIDTH product, {HI, LO}.
  - multu: unsigned 2·WIDTH product, {HI, LO}.
- stall (combinational):
  - Asserted in the issue cycle of mult/multu/div/divu (if not div-by-zero).
  - Asserted while busy for any valid mul/div-class instruction, including mfhi/mflo/mthi/mtlo.
  - Never asserted for other instructions.
  - Deasserted in the DONE cycle.
- While busy, an incoming mul/div op is ignored; the pipeline re-presents it.
- mthi/mtlo: when valid and not busy, HI/LO ← rs_val at the edge.
- mfhi/mflo: hilo_sel = 1 and hilo_out = HI/LO, only when valid and not busy.
- Reset (asynchronous, any state including mid-RUN):
  - State = IDLE, HI = LO = 0, count = 0.
  - busy = done = stall = hilo_sel = 0, hilo_out = 0.
  - An interrupted operation is discarded.

Test Plan:
- Decode sweep: (00, x) → 010; (01, x) → 110; (10, 100010) → 110; (10, 100100) → 000; (10, 100101) → 001; (10, 101010) → 111; (11, 101010) → 111; (10, 111111) → 010.
- mult rs = 0xFFFFFFFD, rt = 5:
  - busy for exactly 32 cycles, done in N+33.
  - HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
  - mfhi afterwards gives hilo_sel = 1, hilo_out = 0xFFFFFFFF.
- multu 0xFFFFFFFF × 2 → HI = 0x00000001, LO = 0xFFFFFFFE.
- div 0xFFFFFFF9 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- div 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- divu 7 / 0 → done in N+1, HI = 7, LO = 0xFFFFFFFF, no busy cycle.
- Interlock:
  - mflo issued during RUN → stall = 1, hilo_sel = 0.
  - mtlo 0x1234 during RUN is ignored.
  - After done, mtlo 0x1234 then mflo → 0x1234.
- rst_n low at cycle 10 of a mult:
  - All outputs 0 immediately (asynchronous).
  - After release, mflo → 0.
  - A fresh mult 3 × 4 gives LO = 12.
